// File: rtl/app_nch_ctrl.sv
// ---------------------------------------------------------------------------
// app_nch_ctrl
//   N-channel controller for the analog photon processor front end.
//   Each channel synchronises its comparator, measures time-over-threshold
//   (TOT) in clock cycles with an optional timeout, then re-arms the analog
//   channel with a timed rst_init pulse. Completed events are tagged
//   {ch, timeout, tot, meta}, arbitrated (lowest channel index first) and
//   buffered in a show-ahead FIFO.
//
// Ports
//   clk                system clock
//   resetb             asynchronous active-low reset, clears all state
//   vcomp[NCH]         asynchronous comparator outputs
//   ch_enable[NCH]     per-channel enable; low forces the channel to IDLE
//   timeout_enable     global timeout enable
//   timeout_threshold  timeout in cycles, 0 disables timeout
//   metadata           tag captured when an event starts
//   rst_init[NCH]      per-channel analog re-arm pulse
//   rd_en              pop head event (ignored when empty)
//   ev_valid           FIFO not empty
//   ev_data            head event {ch, timeout, tot, meta}, 0 when empty
//   fifo_full          FIFO holds FIFO_DEPTH entries
//   drop_count         events lost to a full FIFO, saturating at 255
// ---------------------------------------------------------------------------
module app_nch_ctrl #(
  parameter  int NCH        = 4,
  parameter  int CNT_W      = 16,
  parameter  int META_W     = 8,
  parameter  int FIFO_DEPTH = 8,
  parameter  int RST_CYC    = 4,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int EV_W       = CH_W + 1 + CNT_W + META_W
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [NCH-1:0]    vcomp,
  input  logic [NCH-1:0]    ch_enable,
  input  logic              timeout_enable,
  input  logic [CNT_W-1:0]  timeout_threshold,
  input  logic [META_W-1:0] metadata,
  output logic [NCH-1:0]    rst_init,
  input  logic              rd_en,
  output logic              ev_valid,
  output logic [EV_W-1:0]   ev_data,
  output logic              fifo_full,
  output logic [7:0]        drop_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEAS,
    ST_DONE,
    ST_RESET
  } ch_state_e;

  // Synchroniser and edge detect
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] vs_q;
  logic [NCH-1:0] vs_prev_q;
  logic [NCH-1:0] rise;

  // Per-channel state
  ch_state_e         state_q [NCH];
  ch_state_e         state_d [NCH];
  logic [CNT_W-1:0]  cnt_q   [NCH];
  logic [CNT_W-1:0]  cnt_d   [NCH];
  logic [META_W-1:0] meta_q  [NCH];
  logic [META_W-1:0] meta_d  [NCH];
  logic [RC_W-1:0]   rcnt_q  [NCH];
  logic [RC_W-1:0]   rcnt_d  [NCH];
  logic [NCH-1:0]    flag_q;
  logic [NCH-1:0]    flag_d;

  // Arbitration / FIFO
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    drop_ev;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              found;
  logic [EV_W-1:0]   ev_in;
  logic [EV_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [8:0]        ndrop;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_d;
  logic [7:0]        drop_q;
  logic              to_armed;

  // -------------------------------------------------------------------------
  // Comparator synchronisers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q   <= '0;
      vs_q      <= '0;
      vs_prev_q <= '0;
    end else begin
      sync1_q   <= vcomp;
      vs_q      <= sync1_q;
      vs_prev_q <= vs_q;
    end
  end

  assign rise     = vs_q & ~vs_prev_q;
  assign to_armed = timeout_enable && (timeout_threshold != '0);

  // -------------------------------------------------------------------------
  // Arbitration: one push per cycle, lowest channel index wins. When the
  // FIFO is full and not popping, every pending event is discarded.
  // -------------------------------------------------------------------------
  assign ev_valid  = (count_q != '0);
  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = rd_en && ev_valid;
  assign push_ok   = !fifo_full || pop;

  always_comb begin
    req     = '0;
    grant   = '0;
    drop_ev = '0;
    ev_in   = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      req[i] = (state_q[i] == ST_DONE) && ch_enable[i];
    end
    if (push_ok) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (req[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
          ev_in    = {CH_W'(i), flag_q[i], cnt_q[i], meta_q[i]};
        end
      end
    end else begin
      drop_ev = req;
    end
  end

  assign push = |grant;

  // -------------------------------------------------------------------------
  // Per-channel FSM next state. In MEAS a falling vs takes priority over the
  // timeout, so a fall on the threshold cycle reports a normal end. On
  // timeout cnt already equals the threshold, so cnt doubles as tot.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      meta_d[i]  = meta_q[i];
      rcnt_d[i]  = rcnt_q[i];
      flag_d[i]  = flag_q[i];
      if (!ch_enable[i]) begin
        state_d[i] = ST_IDLE;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              state_d[i] = ST_MEAS;
              cnt_d[i]   = CNT_W'(1);
              meta_d[i]  = metadata;
              flag_d[i]  = 1'b0;
            end
          end
          ST_MEAS: begin
            if (!vs_q[i]) begin
              state_d[i] = ST_DONE;
              flag_d[i]  = 1'b0;
            end else if (to_armed && (cnt_q[i] == timeout_threshold)) begin
              state_d[i] = ST_DONE;
              flag_d[i]  = 1'b1;
            end else if (cnt_q[i] != '1) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          ST_DONE: begin
            if (grant[i] || drop_ev[i]) begin
              state_d[i] = ST_RESET;
              rcnt_d[i]  = RC_W'(RST_CYC - 1);
            end
          end
          ST_RESET: begin
            if (rcnt_q[i] == '0) begin
              state_d[i] = ST_IDLE;
            end else begin
              rcnt_d[i] = rcnt_q[i] - RC_W'(1);
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        meta_q[i]  <= '0;
        rcnt_q[i]  <= '0;
      end
      flag_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        meta_q[i]  <= meta_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
      flag_q <= flag_d;
    end
  end

  // rst_init is gated by the enable so it drops as soon as ch_enable falls
  always_comb begin
    rst_init = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      rst_init[i] = (state_q[i] == ST_RESET) && ch_enable[i];
    end
  end

  // -------------------------------------------------------------------------
  // Drop counter, saturating; several channels may drop on one edge
  // -------------------------------------------------------------------------
  always_comb begin
    ndrop = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ndrop = ndrop + 9'(drop_ev[i]);
    end
    drop_sum = {1'b0, drop_q} + ndrop;
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

  // -------------------------------------------------------------------------
  // Show-ahead event FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ev_in;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ev_data = ev_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_app_nch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_app_nch_ctrl
//   Directed testbench for app_nch_ctrl. A default instance covers pulse
//   measurement, timeout, arbitration order, overflow, disable and reset;
//   a CNT_W=4 instance covers counter saturation.
// ---------------------------------------------------------------------------
module tb_app_nch_ctrl;

  logic        clk = 1'b0;
  logic        resetb;
  logic [3:0]  vcomp;
  logic [3:0]  ch_enable;
  logic        timeout_enable;
  logic [15:0] timeout_threshold;
  logic [7:0]  metadata;
  logic        rd_en;
  logic [3:0]  rst_init;
  logic        ev_valid;
  logic [26:0] ev_data;
  logic        fifo_full;
  logic [7:0]  drop_count;

  logic [3:0]  vcomp_s;
  logic [3:0]  threshold_s;
  logic        rd_en_s;
  logic [3:0]  rst_init_s;
  logic        ev_valid_s;
  logic [14:0] ev_data_s;
  logic        fifo_full_s;
  logic [7:0]  drop_count_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  app_nch_ctrl u_dut (
    .clk               (clk),
    .resetb            (resetb),
    .vcomp             (vcomp),
    .ch_enable         (ch_enable),
    .timeout_enable    (timeout_enable),
    .timeout_threshold (timeout_threshold),
    .metadata          (metadata),
    .rst_init          (rst_init),
    .rd_en             (rd_en),
    .ev_valid          (ev_valid),
    .ev_data           (ev_data),
    .fifo_full         (fifo_full),
    .drop_count        (drop_count)
  );

  app_nch_ctrl #(.CNT_W(4)) u_sat (
    .clk               (clk),
    .resetb            (resetb),
    .vcomp             (vcomp_s),
    .ch_enable         (ch_enable),
    .timeout_enable    (timeout_enable),
    .timeout_threshold (threshold_s),
    .metadata          (metadata),
    .rst_init          (rst_init_s),
    .rd_en             (rd_en_s),
    .ev_valid          (ev_valid_s),
    .ev_data           (ev_data_s),
    .fifo_full         (fifo_full_s),
    .drop_count        (drop_count_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [26:0] mk_ev(input int ch, input bit to, input int tot, input int meta);
    return {2'(ch), to, 16'(tot), 8'(meta)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt;
    int          w;
    logic [26:0] exp_q [7];

    resetb            = 1'b0;
    vcomp             = '0;
    vcomp_s           = '0;
    ch_enable         = 4'hF;
    timeout_enable    = 1'b0;
    timeout_threshold = '0;
    threshold_s       = '0;
    metadata          = '0;
    rd_en             = 1'b0;
    rd_en_s           = 1'b0;
    tick(2);

    // Reset state
    check("rst_rst_init",   rst_init,   4'h0);
    check("rst_ev_valid",   ev_valid,   1'b0);
    check("rst_ev_data",    ev_data,    27'h0);
    check("rst_fifo_full",  fifo_full,  1'b0);
    check("rst_drop_count", drop_count, 8'h0);
    check("rst_sat_outs",   {rst_init_s, ev_valid_s, ev_data_s, fifo_full_s, drop_count_s}, 64'h0);
    resetb = 1'b1;
    tick(2);

    // Single 10-cycle pulse on ch0: DONE on edge 13, push on edge 14
    metadata = 8'hA5;
    vcomp[0] = 1'b1;
    tick(10);
    vcomp[0] = 1'b0;
    tick(3);
    check("t1_not_yet_valid", ev_valid, 1'b0);
    tick(1);
    check("t1_ev_valid", ev_valid, 1'b1);
    check("t1_rst_init", rst_init, 4'b0001);
    check("t1_ev_data",  ev_data,  mk_ev(0, 0, 10, 8'hA5));
    cnt = 1;
    for (int k = 0; k < 20 && rst_init[0]; k++) begin
      tick(1);
      if (rst_init[0]) cnt++;
    end
    check("t1_rst_len", cnt, 4);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("t1_popped", ev_valid, 1'b0);

    // Timeout on ch2, comparator held high
    timeout_threshold = 16'd20;
    timeout_enable    = 1'b1;
    metadata          = 8'h3C;
    vcomp[2]          = 1'b1;
    w = 0;
    while (!ev_valid && w < 60) begin
      tick(1);
      w++;
    end
    check("t2_ev_valid", ev_valid, 1'b1);
    check("t2_ev_data",  ev_data,  mk_ev(2, 1, 20, 8'h3C));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(70);
    check("t2_no_retrigger", ev_valid, 1'b0);
    check("t2_idle_rst",     rst_init, 4'h0);
    vcomp[2] = 1'b0;
    tick(5);
    check("t2_fall_no_event", ev_valid, 1'b0);
    vcomp[2] = 1'b1;
    tick(3);
    vcomp[2] = 1'b0;
    tick(6);
    check("t2_rearm_event", ev_data, mk_ev(2, 0, 3, 8'h3C));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(8);

    // Fall on the threshold cycle: normal end wins
    metadata = 8'h11;
    vcomp[1] = 1'b1;
    tick(20);
    vcomp[1] = 1'b0;
    tick(5);
    check("t2_boundary_ev", ev_data, mk_ev(1, 0, 20, 8'h11));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    timeout_enable = 1'b0;
    tick(8);

    // Simultaneous ends on all channels: one push per cycle, ch0 first
    metadata = 8'h5A;
    vcomp    = 4'hF;
    tick(5);
    vcomp = 4'h0;
    tick(4);
    check("t3_first_push", ev_data, mk_ev(0, 0, 5, 8'h5A));
    tick(3);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_order_ch%0d", i), ev_data, mk_ev(i, 0, 5, 8'h5A));
      tick(1);
    end
    rd_en = 1'b0;
    check("t3_drained", ev_valid, 1'b0);
    tick(8);

    // Overflow: three rounds of 4 events with no reads
    for (int r = 1; r <= 3; r++) begin
      metadata = 8'(r);
      vcomp    = 4'hF;
      tick(5);
      vcomp = 4'h0;
      tick(12);
      if (r == 1) check("t4_r1_not_full", fifo_full, 1'b0);
      if (r == 2) check("t4_r2_full", {fifo_full, drop_count}, {1'b1, 8'd0});
    end
    check("t4_full",       fifo_full,  1'b1);
    check("t4_drop_count", drop_count, 8'd4);
    check("t4_head",       ev_data,    mk_ev(0, 0, 5, 1));

    // Push and pop in the same full cycle: no drop
    metadata = 8'h04;
    vcomp[0] = 1'b1;
    tick(5);
    vcomp[0] = 1'b0;
    tick(3);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("t4_pushpop_full", fifo_full,  1'b1);
    check("t4_pushpop_drop", drop_count, 8'd4);
    check("t4_pushpop_head", ev_data,    mk_ev(1, 0, 5, 1));
    exp_q[0] = mk_ev(2, 0, 5, 1);
    exp_q[1] = mk_ev(3, 0, 5, 1);
    exp_q[2] = mk_ev(0, 0, 5, 2);
    exp_q[3] = mk_ev(1, 0, 5, 2);
    exp_q[4] = mk_ev(2, 0, 5, 2);
    exp_q[5] = mk_ev(3, 0, 5, 2);
    exp_q[6] = mk_ev(0, 0, 5, 4);
    rd_en = 1'b1;
    tick(1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t4_drain_%0d", i), ev_data, exp_q[i]);
      tick(1);
    end
    check("t4_empty", {ev_valid, fifo_full}, 2'b00);
    tick(1);
    check("t4_pop_empty_ignored", ev_valid, 1'b0);
    rd_en = 1'b0;
    tick(2);

    // Disable ch1 during MEAS: event discarded, not counted
    metadata = 8'h77;
    vcomp[1] = 1'b1;
    tick(6);
    ch_enable[1] = 1'b0;
    tick(2);
    check("t5_dis_rst_init", rst_init[1], 1'b0);
    ch_enable[1] = 1'b1;
    tick(5);
    vcomp[1] = 1'b0;
    tick(10);
    check("t5_no_event",   ev_valid,   1'b0);
    check("t5_drop_unchg", drop_count, 8'd4);

    // Disable ch1 during RESET: rst_init drops immediately
    vcomp[1] = 1'b1;
    tick(3);
    vcomp[1] = 1'b0;
    w = 0;
    while (!rst_init[1] && w < 12) begin
      tick(1);
      w++;
    end
    check("t5_rst_high", rst_init[1], 1'b1);
    check("t5_ev_data",  ev_data,     mk_ev(1, 0, 3, 8'h77));
    ch_enable[1] = 1'b0;
    #1;
    check("t5_rst_drop_now", rst_init[1], 1'b0);
    tick(1);
    ch_enable[1] = 1'b1;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(3);

    // Asynchronous reset during RESET clears everything at once
    vcomp[0] = 1'b1;
    tick(4);
    vcomp[0] = 1'b0;
    w = 0;
    while (!rst_init[0] && w < 12) begin
      tick(1);
      w++;
    end
    check("t5_pre_reset", {rst_init[0], ev_valid}, 2'b11);
    #2;
    resetb = 1'b0;
    #1;
    check("t5_areset_rst_init",   rst_init,   4'h0);
    check("t5_areset_ev_valid",   ev_valid,   1'b0);
    check("t5_areset_ev_data",    ev_data,    27'h0);
    check("t5_areset_fifo_full",  fifo_full,  1'b0);
    check("t5_areset_drop_count", drop_count, 8'h0);
    tick(2);
    resetb = 1'b1;
    tick(2);

    // Saturation on the CNT_W=4 instance
    metadata   = 8'hC3;
    vcomp_s[0] = 1'b1;
    tick(30);
    vcomp_s[0] = 1'b0;
    tick(6);
    check("t6_sat_valid", ev_valid_s, 1'b1);
    check("t6_sat_data",  ev_data_s,  {2'd0, 1'b0, 4'hF, 8'hC3});
    rd_en_s = 1'b1;
    tick(1);
    rd_en_s = 1'b0;
    check("t6_sat_popped", ev_valid_s, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/app_nch_ctrl.md
# app_nch_ctrl

Parametrised N-channel digital controller for the analog photon processor front end, successor to the single-channel behavioural controller. Each channel synchronises its comparator output, measures time-over-threshold (TOT) in clock cycles, applies an optional timeout, and re-arms the analog channel through a timed `rst_init` pulse. Completed events from all channels are tagged with channel index, timeout flag and metadata, arbitrated, and buffered in a show-ahead event FIFO read by the readout logic or the analog memory write path.

## Interface
- `NCH`, 4: number of channels (1..16); `CH_W = max(1, clog2(NCH))`
- `CNT_W`, 16: TOT counter and timeout threshold width
- `META_W`, 8: metadata width
- `FIFO_DEPTH`, 8: event FIFO entries (power of two, >= 2)
- `RST_CYC`, 4: `rst_init` pulse length in cycles (>= 1)

- `clk`  in  1  system clock
- `resetb`  in  1  asynchronous active-low reset; clears all state
- `vcomp`  in  NCH  asynchronous comparator outputs, one per channel
- `ch_enable`  in  NCH  per-channel enable
- `timeout_enable`  in  1  global timeout enable
- `timeout_threshold`  in  CNT_W  timeout in cycles; 0 disables timeout
- `metadata`  in  META_W  tag captured at event start
- `rst_init`  out  NCH  per-channel analog re-arm pulse
- `rd_en`  in  1  pop head event
- `ev_valid`  out  1  FIFO not empty
- `ev_data`  out  CH_W+1+CNT_W+META_W  head event = {ch, timeout, tot, meta}
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries
- `drop_count`  out  8  events lost to full FIFO, saturating at 255

## Operation
- Each `vcomp[i]` passes a 2-flop synchroniser → `vs[i]`; a registered copy gives rise detection.
- Per-channel FSM: IDLE, MEAS, DONE, RESET.
- IDLE: on rising `vs` with `ch_enable[i]`=1 → MEAS, cnt<=1, capture `metadata`.
- MEAS: `vs`=1 → cnt<=cnt+1, saturating at all-ones. `vs`=0 → DONE, flag=0, tot=cnt. Timeout: `timeout_enable`=1, threshold≠0, `vs`=1 and cnt==threshold → DONE, flag=1, tot=threshold. If `vs` falls in the same cycle cnt==threshold, the normal end wins (flag=0).
- DONE: requests a push. Granted → write event, → RESET. FIFO full and no simultaneous pop → event discarded, `drop_count`++ (saturating), → RESET.
- RESET: `rst_init[i]`=1 for exactly RST_CYC cycles, `vcomp` ignored, then → IDLE. A new event needs a fresh rising edge, so a still-high comparator after timeout does not retrigger.
- Arbitration: one push per cycle, fixed priority with the lowest channel index first. Ungranted DONE channels hold, with tot/flag/meta frozen.
- FIFO: push allowed when not full, or full with `rd_en` popping in the same cycle. `rd_en` when empty is ignored. `ev_data` is the head entry and is don't-care when `ev_valid`=0.
- `ch_enable[i]`=0 forces the channel to IDLE on the next edge from any state. In-progress or pending events are discarded and not counted. `rst_init[i]` drops immediately.
- `timeout_threshold` and `timeout_enable` are sampled every cycle, not latched per event.

## Timing
- Reset values: `rst_init`=0, `ev_valid`=0, `ev_data`=0, `fifo_full`=0, `drop_count`=0, all FSMs IDLE, synchronisers 0.
- Asynchronous `vcomp` rise to MEAS: 3 edges (2 synchroniser + 1 FSM).
- A synchronised high pulse of N cycles (N ≤ threshold−1 or timeout off) reports tot=N.
- Fall seen → DONE on edge k. Push on edge k+1 if granted. `ev_valid` and `rst_init[i]` are high after edge k+1.
- `rst_init[i]` is high for RST_CYC cycles. The channel is IDLE and can accept a rising edge on the cycle after `rst_init` falls.
- Pop: head advances on the edge with `rd_en`&&`ev_valid`. `fifo_full` and `ev_valid` are registered, updated on the same edge.
- Minimum per-channel event period: 1 + N + 1 + RST_CYC cycles, plus arbitration wait.

## Test plan
- Single pulse: ch0 `vcomp` high 10 cycles, timeout off, metadata=0xA5 → one event {ch=0, to=0, tot=10, meta=0xA5}; `rst_init[0]` high 4 cycles.
- Timeout: threshold=20, enable=1, ch2 held high 100 cycles → event {ch=2, to=1, tot=20}; no second event until `vcomp` falls and rises again.
- Simultaneous ends: ch0..ch3 get identical 5-cycle pulses → events pop in order ch0, ch1, ch2, ch3, one per cycle, all with tot=5.
- Overflow: `rd_en`=0, 12 events → `fifo_full`=1, 8 stored, `drop_count`=4. Push and pop in the same full cycle → no drop.
- Disable and reset mid-event: drop `ch_enable[1]` during MEAS → no event, `rst_init[1]`=0. Assert `resetb`=0 mid-RESET → all outputs 0 immediately.
- Saturation: CNT_W=4, timeout off, pulse 30 cycles → tot=15.
